// File: rtl/controller.sv
// controller: eight-phase instruction sequencer for the RISC CPU.
// Each instruction takes eight clock cycles. The outputs drive the datapath
// register load enables, the memory strobes and the address-bus source select.
// All outputs are decoded combinationally from the phase register and the
// opcode. The current phase is exported on state_dbg so that checkers can
// bind to it.

package typedefs;
    // Instruction opcodes (upper bits of the instruction register)
    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;
endpackage

module controller #(
    parameter int OPCODE_W = $bits(typedefs::opcode_t)
) (
    input  logic                clock,
    input  logic                aresetn,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                sel,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                load_ir,
    output logic                load_ac,
    output logic                load_pc,
    output logic                inc_pc,
    output logic                halt,
    output logic [2:0]          state_dbg
);

    // Phase encoding follows execution order, so state_dbg reads 0..7 as an
    // instruction progresses.
    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

    localparam logic [OPCODE_W-1:0] HLT = OPCODE_W'(typedefs::OP_HLT);
    localparam logic [OPCODE_W-1:0] SKZ = OPCODE_W'(typedefs::OP_SKZ);
    localparam logic [OPCODE_W-1:0] ADD = OPCODE_W'(typedefs::OP_ADD);
    localparam logic [OPCODE_W-1:0] AND = OPCODE_W'(typedefs::OP_AND);
    localparam logic [OPCODE_W-1:0] XOR = OPCODE_W'(typedefs::OP_XOR);
    localparam logic [OPCODE_W-1:0] LDA = OPCODE_W'(typedefs::OP_LDA);
    localparam logic [OPCODE_W-1:0] STO = OPCODE_W'(typedefs::OP_STO);
    localparam logic [OPCODE_W-1:0] JMP = OPCODE_W'(typedefs::OP_JMP);

    state_t state;
    state_t state_next;
    logic   halted;
    logic   halted_next;

    logic   is_hlt;
    logic   is_skz;
    logic   is_sto;
    logic   is_jmp;
    logic   aluop;

    // Opcode class decode shared by the output logic
    always_comb begin
        is_hlt = (opcode == HLT);
        is_skz = (opcode == SKZ);
        is_sto = (opcode == STO);
        is_jmp = (opcode == JMP);
        aluop  = (opcode == ADD) || (opcode == AND) ||
                 (opcode == XOR) || (opcode == LDA);
    end

    // Phase register and sticky halt flag. Both are cleared asynchronously,
    // and reset lands in INST_ADDR, so the reset outputs are sel=1 and
    // everything else 0.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state  <= INST_ADDR;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            halted <= halted_next;
        end
    end

    // Next phase and output decode. Defaults are set first, so an unlisted
    // output is 0 and an unknown encoding returns to INST_ADDR.
    always_comb begin
        state_next  = INST_ADDR;
        halted_next = halted;
        sel         = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        load_ir     = 1'b0;
        load_ac     = 1'b0;
        load_pc     = 1'b0;
        inc_pc      = 1'b0;
        halt        = 1'b0;

        case (state)
            INST_ADDR: begin
                sel        = 1'b1;
                state_next = INST_FETCH;
            end
            INST_FETCH: begin
                sel        = 1'b1;
                mem_rd     = 1'b1;
                state_next = INST_LOAD;
            end
            INST_LOAD: begin
                sel        = 1'b1;
                mem_rd     = 1'b1;
                load_ir    = 1'b1;
                state_next = IDLE;
            end
            IDLE: begin
                // The IR is loaded a second time with the same value.
                sel        = 1'b1;
                mem_rd     = 1'b1;
                load_ir    = 1'b1;
                state_next = OP_ADDR;
            end
            OP_ADDR: begin
                // A HLT instruction parks the sequencer here. The PC advances
                // once, on the first cycle. After that the sticky flag
                // suppresses the increment until reset.
                inc_pc = !halted;
                halt   = is_hlt || halted;
                if (is_hlt || halted) begin
                    state_next  = OP_ADDR;
                    halted_next = 1'b1;
                end else begin
                    state_next  = OP_FETCH;
                end
            end
            OP_FETCH: begin
                mem_rd     = aluop;
                state_next = ALU_OP;
            end
            ALU_OP: begin
                // zero is used only in this phase, to skip the next instruction.
                mem_rd     = aluop;
                load_ac    = aluop;
                inc_pc     = is_skz && zero;
                load_pc    = is_jmp;
                state_next = STORE;
            end
            STORE: begin
                // For JMP, load_pc overrides inc_pc inside the PC.
                mem_rd     = aluop;
                load_ac    = aluop;
                inc_pc     = is_jmp;
                load_pc    = is_jmp;
                mem_wr     = is_sto;
                state_next = INST_ADDR;
            end
            default: begin
                state_next = INST_ADDR;
            end
        endcase
    end

    // Phase exported for observation
    always_comb begin
        state_dbg = state;
    end

    // Memory write never coincides with a memory read
    a_wr_rd_exclusive: assert property (@(posedge clock) disable iff (!aresetn)
        !(mem_wr && mem_rd));

    // Jump load and accumulator load never coincide
    a_pc_ac_exclusive: assert property (@(posedge clock) disable iff (!aresetn)
        !(load_pc && load_ac));

endmodule

// File: tb/tb_controller.sv
// tb_controller: randomized stimulus against a cycle-number reference model.
module tb_controller;

    logic       clock;
    logic       aresetn;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt;
    logic [2:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    // Reference model state: cycle within the instruction (1..8), halt flag
    int m_cycle;
    bit m_halted;
    int op_mode;      // -1: random non-HLT opcode per instruction, else fixed
    int inc_count;

    controller dut (
        .clock    (clock),
        .aresetn  (aresetn),
        .opcode   (opcode),
        .zero     (zero),
        .sel      (sel),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .load_ir  (load_ir),
        .load_ac  (load_ac),
        .load_pc  (load_pc),
        .inc_pc   (inc_pc),
        .halt     (halt),
        .state_dbg(state_dbg)
    );

    // Clock generation
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count one comparison and report it if the values differ
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] outs();
        return {sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt};
    endfunction

    // Expected outputs from the instruction timeline, by cycle number 1..8
    function automatic logic [7:0] model(input int cyc, input logic [2:0] op,
                                         input logic z, input bit hl);
        bit alu, e_sel, e_rd, e_wr, e_ir, e_ac, e_pc, e_inc, e_halt;
        alu    = (op >= 3'd2) && (op <= 3'd5);
        e_sel  = (cyc <= 4);
        e_rd   = (cyc >= 2 && cyc <= 4) || (cyc >= 6 && alu);
        e_ir   = (cyc == 3 || cyc == 4);
        e_ac   = (cyc >= 7) && alu;
        e_pc   = (cyc >= 7) && (op == 3'd7);
        e_wr   = (cyc == 8) && (op == 3'd6);
        e_inc  = (cyc == 5 && !hl) || (cyc == 7 && op == 3'd1 && z) ||
                 (cyc == 8 && op == 3'd7);
        e_halt = (cyc == 5) && (op == 3'd0 || hl);
        return {e_sel, e_rd, e_wr, e_ir, e_ac, e_pc, e_inc, e_halt};
    endfunction

    // Drive this cycle's inputs, check outputs and phase, advance the model
    task automatic apply_and_check();
        logic [7:0] e;
        if (m_cycle == 1)
            opcode = (op_mode < 0) ? 3'($urandom_range(1, 7)) : 3'(op_mode);
        zero = 1'($urandom_range(0, 1));
        #1;
        exp_q.push_back(model(m_cycle, opcode, zero, m_halted));
        e = exp_q.pop_front();
        check("outputs", outs(), e);
        check("phase", {5'd0, state_dbg}, 8'(m_cycle - 1));
        if (inc_pc) inc_count++;
        if (m_cycle == 5 && (opcode == 3'd0 || m_halted))
            m_halted = 1'b1;
        else
            m_cycle = (m_cycle % 8) + 1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            apply_and_check();
        end
    endtask

    // Assert reset part-way through the high clock phase, check, and release
    // at the next falling edge
    task automatic async_reset(input int dly);
        @(posedge clock);
        #(dly);
        aresetn = 1'b0;
        #1;
        check("reset_outs", outs(), 8'b1000_0000);
        check("reset_phase", {5'd0, state_dbg}, 8'd0);
        @(negedge clock);
        aresetn  = 1'b1;
        m_cycle  = 1;
        m_halted = 1'b0;
        apply_and_check();
    endtask

    // Stimulus
    initial begin
        aresetn   = 1'b0;
        opcode    = 3'd0;
        zero      = 1'b0;
        op_mode   = 2;
        m_cycle   = 1;
        m_halted  = 1'b0;
        inc_count = 0;
        #2;
        check("por_outs", outs(), 8'b1000_0000);
        check("por_phase", {5'd0, state_dbg}, 8'd0);

        async_reset(3);

        // ADD, STO, JMP, then SKZ twice with a random zero input
        run_cycles(15);
        op_mode = 6; run_cycles(8);
        op_mode = 7; run_cycles(8);
        op_mode = 1; run_cycles(16);
        op_mode = 3; run_cycles(8);

        // Random instruction stream with occasional mid-instruction reset
        op_mode = -1;
        for (int k = 0; k < 6; k++) begin
            run_cycles($urandom_range(20, 60));
            async_reset($urandom_range(1, 4));
        end
        run_cycles(7);

        // HLT: walk to the next INST_ADDR, then park and count increments
        op_mode = 0;
        while (m_cycle != 1) run_cycles(1);
        inc_count = 0;
        run_cycles(30);
        check("hlt_inc_pulses", 8'(inc_count), 8'd1);
        async_reset(2);
        op_mode = -1;
        run_cycles(16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/controller.md
# controller

Eight-phase instruction sequencer for the RISC CPU. It drives the load enables of the datapath registers (instruction register, accumulator, program counter), the memory read/write strobes, and the address-bus source select. One instruction executes every 8 clock cycles. It sits directly upstream of every parallel-load register in the datapath: its `load_ir`, `load_ac` and `load_pc` outputs are those registers' `load` inputs.

## Interface
- `OPCODE_W`, default 3: opcode width, taken from `typedefs::opcode_t`.
- `clock`, input, 1: system clock; all state changes on the rising edge.
- `aresetn`, input, 1: asynchronous, active-low reset.
- `opcode`, input, `OPCODE_W`: upper bits of the instruction-register output; treated as stable from INST_LOAD through STORE.
- `zero`, input, 1: accumulator-is-zero flag from the ALU.
- `sel`, output, 1: address mux select; 1 = PC, 0 = instruction operand field.
- `mem_rd`, output, 1: memory read strobe.
- `mem_wr`, output, 1: memory write strobe.
- `load_ir`, output, 1: instruction-register load enable.
- `load_ac`, output, 1: accumulator load enable.
- `load_pc`, output, 1: program-counter parallel load (jump).
- `inc_pc`, output, 1: program-counter increment enable.
- `halt`, output, 1: processor halted.

## Operation
- Opcode encoding: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- The state register holds one of 8 phases, in fixed order: INST_ADDR → INST_FETCH → INST_LOAD → IDLE → OP_ADDR → OP_FETCH → ALU_OP → STORE → INST_ADDR.
- All outputs are decoded combinationally from the current state and `opcode`. Any output not listed for a state is 0.
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, mem_rd=1.
  - INST_LOAD: sel=1, mem_rd=1, load_ir=1.
  - IDLE: sel=1, mem_rd=1, load_ir=1.
  - OP_ADDR: inc_pc=1; halt=1 if opcode==HLT.
  - OP_FETCH: mem_rd=ALUOP.
  - ALU_OP: mem_rd=ALUOP; load_ac=ALUOP; inc_pc=(opcode==SKZ && zero); load_pc=(opcode==JMP).
  - STORE: mem_rd=ALUOP; load_ac=ALUOP; inc_pc=(opcode==JMP); load_pc=(opcode==JMP); mem_wr=(opcode==STO).
- Halt behaviour:
  - When the state is OP_ADDR and opcode==HLT, the FSM does not advance. It remains in OP_ADDR with halt=1 and inc_pc=1 on the first cycle only.
  - On subsequent halted cycles, inc_pc=0 and halt=1. A sticky `halted` flag is set on the first halted edge and gates inc_pc.
  - Only reset leaves the halted condition.
- An illegal or unreachable state encoding returns to INST_ADDR on the next edge, with all outputs 0 for that cycle.

## Timing
- Reset (aresetn=0, asynchronous): state=INST_ADDR and halted=0, applied immediately without waiting for a clock.
  - Outputs during reset: sel=1; mem_rd=mem_wr=load_ir=load_ac=load_pc=inc_pc=halt=0.
- Release: the first rising edge with aresetn=1 moves the FSM to INST_FETCH.
- Reset mid-instruction aborts the instruction. No partial load or write strobe survives the reset assertion.
- Latency: exactly 8 cycles per non-halt instruction. `load_ir` is high for 2 consecutive cycles, so the IR captures on the INST_LOAD edge and again, identically, on the IDLE edge.
- Enable pulse widths:
  - `load_ac` is high for 2 cycles (ALU_OP, STORE); the accumulator captures its final value on the STORE edge.
  - `load_pc` with `inc_pc` asserted together in STORE: load takes priority in the PC, and the jump target is loaded.
- `mem_wr` is high for exactly 1 cycle (STORE) and never overlaps `mem_rd`.
- SKZ with zero=1: exactly one extra inc_pc cycle (in ALU_OP), giving a skip of one instruction. With zero=0 there is no extra inc_pc.
- `zero` is sampled combinationally only during ALU_OP; changes in other states have no effect.

## Test plan
- Reset and first fetch: assert aresetn=0 mid-cycle → outputs go immediately to sel=1, others 0. Release → states advance INST_FETCH (mem_rd=1), then INST_LOAD (load_ir=1).
- ADD (opcode=2), zero=0, over one full 8-cycle instruction:
  - load_ir high in cycles 3–4 and inc_pc high in cycle 5.
  - mem_rd high in cycles 2–4 and 6–8; load_ac high in cycles 7–8.
  - mem_wr and load_pc never high.
- STO (opcode=6): mem_wr=1 only in STORE; mem_rd=0 and load_ac=0 throughout OP_FETCH/ALU_OP/STORE.
- JMP (opcode=7): load_pc=1 in ALU_OP and STORE; inc_pc=1 in OP_ADDR and STORE; load_ac never high.
- SKZ (opcode=1): with zero=1 → inc_pc in OP_ADDR and ALU_OP (2 pulses per instruction); with zero=0 → 1 pulse only.
- HLT (opcode=0): FSM parks in OP_ADDR, halt=1, inc_pc pulses exactly once, and the state is unchanged for 20 further cycles. Then aresetn=0 → state=INST_ADDR and halt=0.
